// File: rtl/mul256mod_if.sv
// rtl/mul256mod_if.sv - operand/result handshake bundle for mul256mod
//
// Purpose: groups the operand, start and result signals of the modular
// multiplier so the datapath and its client connect through one port.
//
// Signals:
//   datax  [255:0]  multiplicand (client -> multiplier)
//   datay  [255:0]  multiplier   (client -> multiplier)
//   update          start pulse  (client -> multiplier)
//   dataz  [255:0]  product mod n, held until next completion (multiplier -> client)
//   done            one-cycle completion pulse (multiplier -> client)
//   busy            operation in flight (multiplier -> client)
//
// Modports: master = client side, slave = multiplier side.

interface mul256mod_if;
  logic [255:0] datax;
  logic [255:0] datay;
  logic         update;
  logic [255:0] dataz;
  logic         done;
  logic         busy;

  modport master (
    output datax,
    output datay,
    output update,
    input  dataz,
    input  done,
    input  busy
  );

  modport slave (
    input  datax,
    input  datay,
    input  update,
    output dataz,
    output done,
    output busy
  );
endinterface

// File: rtl/mul256mod.sv
// rtl/mul256mod.sv - iterative 256-bit modular multiplier, dataz = datax*datay mod n
//
// Purpose: MSB-first interleaved double-and-add modular multiplication, one
// multiplier bit per clock. Default build runs a fixed 256 iterations
// (constant-time, 257 clocks from accepted update to done).
//
// Optional feature (macro MUL256MOD_EARLYSKIP_EN): leading zero bits of the
// multiplier are skipped via a priority encoder; latency becomes
// data-dependent and a zero multiplier completes one clock after update.
//
// Parameters:
//   modz   modulus n (default secp256k1 group order); must satisfy
//          2^255 < modz < 2^256.
//
// Ports:
//   clk    system clock, rising edge
//   rstn   asynchronous active-low reset
//   bus    mul256mod_if.slave: datax, datay, update in; dataz, done, busy out

module mul256mod #(
  parameter logic [255:0] modz =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141
) (
  input  logic        clk,
  input  logic        rstn,
  mul256mod_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [255:0] acc_q,   acc_d;
  logic [255:0] xr_q,    xr_d;
  logic [255:0] yr_q,    yr_d;
  logic [7:0]   idx_q,   idx_d;
  logic [255:0] dataz_q, dataz_d;
  logic         done_q,  done_d;
  logic         busy_q,  busy_d;

  // One iteration: t = 2*acc + bit*xr < 3n, then subtract 0, n or 2n.
  // All three candidates are formed in parallel; the sign bit of each
  // 259-bit difference says whether that candidate is non-negative.
  logic [257:0] t;
  logic [258:0] d1;
  logic [258:0] d2;
  logic [255:0] r0, r1, r2;
  logic [255:0] acc_step;

  always_comb begin
    t  = {1'b0, acc_q, 1'b0} + (yr_q[idx_q] ? {2'b00, xr_q} : 258'd0);
    d1 = {1'b0, t} - {3'b000, modz};
    d2 = {1'b0, t} - {2'b00, modz, 1'b0};
    r0 = 256'(t);
    r1 = 256'(d1);
    r2 = 256'(d2);
    if (!d2[258]) begin
      acc_step = r2;
    end else if (!d1[258]) begin
      acc_step = r1;
    end else begin
      acc_step = r0;
    end
  end

`ifdef MUL256MOD_EARLYSKIP_EN
  // Position of the most significant set bit; 0 when v==0 (caller
  // handles the all-zero case separately).
  function automatic logic [7:0] msb_pos(input logic [255:0] v);
    logic [7:0] p;
    p = 8'd0;
    for (int i = 0; i < 256; i++) begin
      if (v[i]) p = 8'(i);
    end
    return p;
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    xr_d    = xr_q;
    yr_d    = yr_q;
    idx_d   = idx_q;
    dataz_d = dataz_q;
    done_d  = 1'b0;
    busy_d  = busy_q;

    unique case (state_q)
      IDLE: begin
        if (bus.update) begin
          xr_d    = bus.datax;
          yr_d    = bus.datay;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end

      LOAD: begin
        // modz > 2^255, so any 256-bit xr is below 2n: one subtraction
        // fully reduces it.
        xr_d    = (xr_q >= modz) ? (xr_q - modz) : xr_q;
        acc_d   = 256'd0;
        state_d = RUN;
`ifdef MUL256MOD_EARLYSKIP_EN
        // acc stays 0 across leading zero multiplier bits, so starting
        // at the top set bit gives the same result.
        idx_d = msb_pos(yr_q);
        if (yr_q == 256'd0) begin
          dataz_d = 256'd0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
`else
        idx_d = 8'd255;
`endif
      end

      RUN: begin
        acc_d = acc_step;
        idx_d = idx_q - 8'd1;
        if (idx_q == 8'd0) begin
          dataz_d = acc_step;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      acc_q   <= 256'd0;
      xr_q    <= 256'd0;
      yr_q    <= 256'd0;
      idx_q   <= 8'd0;
      dataz_q <= 256'd0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      xr_q    <= xr_d;
      yr_q    <= yr_d;
      idx_q   <= idx_d;
      dataz_q <= dataz_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.dataz = dataz_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_mul256mod.sv
// tb/tb_mul256mod.sv - self-checking bench for mul256mod

module tb_mul256mod;

  localparam logic [255:0] N =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;
  localparam logic [255:0] ALL1_MOD =
    256'h1_45512319_50B75FC4_402DA173_2FC9BEBE;

  logic clk;
  logic rstn;
  int   errors;
  int   checks;

  mul256mod_if bus ();

  mul256mod dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [255:0] ref_mul(input logic [255:0] x, input logic [255:0] y);
    logic [511:0] p;
    p = {256'd0, x} * {256'd0, y};
    p = p % {256'd0, N};
    return p[255:0];
  endfunction

  function automatic int exp_lat(input logic [255:0] y);
`ifdef MUL256MOD_EARLYSKIP_EN
    int top;
    if (y == 256'd0) return 1;
    top = 0;
    for (int i = 0; i < 256; i++) if (y[i]) top = i;
    return top + 2;
`else
    return (y == y) ? 257 : 257;
`endif
  endfunction

  // Call at a negedge. Drives one update pulse (sampled at the next posedge)
  // and returns at the negedge right after that edge; operands are then
  // scrambled since the design must not sample them again.
  task automatic launch(input logic [255:0] x, input logic [255:0] y);
    bus.datax  = x;
    bus.datay  = y;
    bus.update = 1'b1;
    @(negedge clk);
    bus.update = 1'b0;
    bus.datax  = rnd256();
    bus.datay  = rnd256();
  endtask

  // Waits for done, counting cycles since the accepted update. If inj>=0 a
  // spurious update with random operands is pulsed at that cycle.
  task automatic wait_result(input logic [255:0] exp_z, input int lat,
                             input int inj, input string name);
    int m;
    int bcnt;
    m    = 0;
    bcnt = 0;
    while (bus.done !== 1'b1 && m < 600) begin
      if (bus.busy === 1'b1) bcnt++;
      if (m == inj) begin
        bus.update = 1'b1;
        bus.datax  = rnd256();
        bus.datay  = rnd256();
      end else if (inj >= 0 && m == inj + 1) begin
        bus.update = 1'b0;
      end
      @(negedge clk);
      m++;
    end
    bus.update = 1'b0;
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: no done after %0d cycles, want done at %0d", name, m, lat);
      return;
    end
    checks++;
    if (m !== lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d want %0d", name, m, lat);
    end
    checks++;
    if (bcnt !== lat) begin
      errors++;
      $display("FAIL %s_busy_cycles: got %0d want %0d", name, bcnt, lat);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy_at_done: got %b want 0", name, bus.busy);
    end
    checks++;
    if (bus.dataz !== exp_z) begin
      errors++;
      $display("FAIL %s_dataz: got %h want %h", name, bus.dataz, exp_z);
    end
  endtask

  task automatic test_reset();
    rstn       = 1'b0;
    bus.update = 1'b0;
    bus.datax  = 256'd0;
    bus.datay  = 256'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.dataz !== 256'd0) begin
      errors++;
      $display("FAIL reset_state: done=%b busy=%b dataz=%h want 0 0 0",
               bus.done, bus.busy, bus.dataz);
    end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: done=%b busy=%b want 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_basic();
    launch(256'd3, 256'd5);
    wait_result(256'd15, exp_lat(256'd5), -1, "basic");
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL done_width: done still %b one cycle later, want 0", bus.done);
    end
    checks++;
    if (bus.dataz !== 256'd15) begin
      errors++;
      $display("FAIL dataz_hold: got %h want %h", bus.dataz, 256'd15);
    end
  endtask

  task automatic test_corners();
    logic [255:0] xs [6];
    logic [255:0] ys [6];
    logic [255:0] zs [6];
    xs[0] = N - 1;             ys[0] = N - 1;       zs[0] = 256'd1;
    xs[1] = N - 1;             ys[1] = 256'd2;      zs[1] = N - 2;
    xs[2] = N + 5;             ys[2] = 256'd2;      zs[2] = 256'd10;
    xs[3] = '1;                ys[3] = 256'd1;      zs[3] = ALL1_MOD;
    xs[4] = rnd256();          ys[4] = 256'd0;      zs[4] = 256'd0;
    xs[5] = 256'd0;            ys[5] = '1;          zs[5] = 256'd0;
    for (int i = 0; i < 6; i++) begin
      launch(xs[i], ys[i]);
      wait_result(zs[i], exp_lat(ys[i]), -1, $sformatf("corner%0d", i));
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [255:0] x;
    logic [255:0] y;
    for (int i = 0; i < 6; i++) begin
      x = rnd256();
      y = rnd256();
      if (i == 4) y = y >> $urandom_range(200, 250);
      launch(x, y);
      wait_result(ref_mul(x, y), exp_lat(y), -1, $sformatf("random%0d", i));
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  task automatic test_ignore_busy();
    launch(256'd3, 256'd5);
    wait_result(256'd15, exp_lat(256'd5), 100, "ignore_update");
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [255:0] x1, y1, x2, y2;
    x1 = rnd256(); y1 = rnd256();
    x2 = rnd256(); y2 = rnd256();
    launch(x1, y1);
    wait_result(ref_mul(x1, y1), exp_lat(y1), -1, "b2b_first");
    launch(x2, y2);
    wait_result(ref_mul(x2, y2), exp_lat(y2), -1, "b2b_second");
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [255:0] x, y;
    int stray;
    x = rnd256();
    y = rnd256();
    y[255] = 1'b1;
    launch(x, y);
    repeat (128) @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.dataz !== 256'd0) begin
      errors++;
      $display("FAIL async_reset: done=%b busy=%b dataz=%h want 0 0 0",
               bus.done, bus.busy, bus.dataz);
    end
    repeat (2) @(negedge clk);
    rstn  = 1'b1;
    stray = 0;
    repeat (300) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++;
      $display("FAIL no_stray_done: got %0d active cycles want 0", stray);
    end
    launch(256'd7, 256'd9);
    wait_result(256'd63, exp_lat(256'd9), -1, "after_reset");
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rstn   = 1'b0;
    test_reset();
    test_basic();
    test_corners();
    test_random();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
